// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared constants for the ID/EX stage: default widths, ALU control codes, the zero register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package id_ex_fwd_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CTRL_W = 4;

    // Register 0 is hard-wired to zero and must never be a forwarding target.
    localparam int REG_ZERO = 0;

    // ALU control encodings driven on alu_ctrl_o.
    localparam logic [DEF_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [DEF_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [DEF_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [DEF_CTRL_W-1:0] ALU_SUB = 4'b0011;
    localparam logic [DEF_CTRL_W-1:0] ALU_SR  = 4'b0100;
    localparam logic [DEF_CTRL_W-1:0] ALU_SLT = 4'b0110;
    localparam logic [DEF_CTRL_W-1:0] ALU_SUP = 4'b0111;
    localparam logic [DEF_CTRL_W-1:0] ALU_BEQ = 4'b1010;
    localparam logic [DEF_CTRL_W-1:0] ALU_BNE = 4'b1011;
    localparam logic [DEF_CTRL_W-1:0] ALU_SRA = 4'b1111;

endpackage

// File: rtl/id_ex_fwd_stage_fwd_mux.sv
// One operand forwarding comparator + mux: picks EX/MEM, then MEM/WB, then the stored value.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
// Ports: src_reg/stored_data = operand being resolved; exmem_*/memwb_* = the two writer
// stages; fwd_data = resolved operand value.
module id_ex_fwd_stage_fwd_mux
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] fwd_data
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_regwrite && (exmem_rd != REG_AW'(REG_ZERO)) && (exmem_rd == src_reg);
    assign memwb_hit = memwb_regwrite && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == src_reg);

    // The younger EX/MEM result wins when both stages write the same register.
    always_comb begin
        fwd_data = stored_data;
        if (exmem_hit) begin
            fwd_data = exmem_result;
        end else if (memwb_hit) begin
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with rs/rt operand forwarding and load-use detection for the ALU.
// Latency: 1 cycle ID -> EX register; forwarding and load_use_o are combinational.
// Backpressure: stall_i holds the stage (operands refresh from forwarding), flush_i loads a bubble.
// Ports: clk_i/rst_i (sync, active-low); stall_i/flush_i from the hazard unit; id_* decoded
// instruction; exmem_*/memwb_* writer stages; alu_* ALU inputs; store_data_o; ex_* stage
// controls; load_use_o hazard flag.
module id_ex_fwd_stage
    import id_ex_fwd_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [CTRL_W-1:0] id_alu_ctrl_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_alusrc_i,
    input  logic              id_regdst_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              id_memtoreg_i,
    input  logic              id_branch_i,
    input  logic              id_uses_rt_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [4:0]        alu_shift_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] ex_dst_o,
    output logic              ex_valid_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_branch_o,
    output logic              load_use_o
);

    logic              ex_valid_q;
    logic              ex_regwrite_q;
    logic              ex_memread_q;
    logic              ex_memwrite_q;
    logic              ex_memtoreg_q;
    logic              ex_branch_q;
    logic              ex_alusrc_q;
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic [REG_AW-1:0] ex_dst_q;
    logic [DATA_W-1:0] ex_rs_data_q;
    logic [DATA_W-1:0] ex_rt_data_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [4:0]        ex_shamt_q;
    logic [CTRL_W-1:0] ex_ctrl_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    id_ex_fwd_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_reg        (ex_rs_q),
        .stored_data    (ex_rs_data_q),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_rd       (exmem_rd_i),
        .exmem_result   (exmem_result_i),
        .memwb_regwrite (memwb_regwrite_i),
        .memwb_rd       (memwb_rd_i),
        .memwb_data     (memwb_data_i),
        .fwd_data       (fwd_rs)
    );

    id_ex_fwd_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_reg        (ex_rt_q),
        .stored_data    (ex_rt_data_q),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_rd       (exmem_rd_i),
        .exmem_result   (exmem_result_i),
        .memwb_regwrite (memwb_regwrite_i),
        .memwb_rd       (memwb_rd_i),
        .memwb_data     (memwb_data_i),
        .fwd_data       (fwd_rt)
    );

    // Reset and flush both leave an all-zero bubble; flush beats stall.
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_branch_q   <= 1'b0;
            ex_alusrc_q   <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_dst_q      <= '0;
            ex_rs_data_q  <= '0;
            ex_rt_data_q  <= '0;
            ex_imm_q      <= '0;
            ex_shamt_q    <= '0;
            ex_ctrl_q     <= '0;
        end else if (stall_i) begin
            // Operands keep tracking forwarded values so a writer that retires from
            // MEM/WB while we are stalled is captured before it disappears.
            ex_rs_data_q  <= fwd_rs;
            ex_rt_data_q  <= fwd_rt;
        end else begin
            ex_valid_q    <= id_valid_i;
            ex_regwrite_q <= id_regwrite_i & id_valid_i;
            ex_memread_q  <= id_memread_i  & id_valid_i;
            ex_memwrite_q <= id_memwrite_i & id_valid_i;
            ex_memtoreg_q <= id_memtoreg_i & id_valid_i;
            ex_branch_q   <= id_branch_i   & id_valid_i;
            ex_alusrc_q   <= id_alusrc_i   & id_valid_i;
            ex_rs_q       <= id_rs_i;
            ex_rt_q       <= id_rt_i;
            ex_dst_q      <= id_regdst_i ? id_rd_i : id_rt_i;
            ex_rs_data_q  <= id_rs_data_i;
            ex_rt_data_q  <= id_rt_data_i;
            ex_imm_q      <= id_imm_i;
            ex_shamt_q    <= id_shamt_i;
            ex_ctrl_q     <= id_alu_ctrl_i;
        end
    end

    assign alu_src1_o    = fwd_rs;
    assign alu_src2_o    = ex_alusrc_q ? ex_imm_q : fwd_rt;
    assign store_data_o  = fwd_rt;
    assign alu_ctrl_o    = ex_ctrl_q;
    assign alu_shift_o   = ex_shamt_q;
    assign ex_dst_o      = ex_dst_q;
    assign ex_valid_o    = ex_valid_q;
    assign ex_regwrite_o = ex_regwrite_q;
    assign ex_memread_o  = ex_memread_q;
    assign ex_memwrite_o = ex_memwrite_q;
    assign ex_memtoreg_o = ex_memtoreg_q;
    assign ex_branch_o   = ex_branch_q;

    // A load in EX whose destination is a source of the instruction now in ID.
    assign load_use_o = ex_valid_q && ex_memread_q && (ex_dst_q != REG_AW'(REG_ZERO)) &&
                        ((ex_dst_q == id_rs_i) || (id_uses_rt_i && (ex_dst_q == id_rt_i)));

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Bench for id_ex_fwd_stage: directed scenarios plus a randomized run against a stage model.
// Latency: checks combinational outputs before each edge, registered state after it.
// Backpressure: exercises stall_i / flush_i / reset priority.
module tb_id_ex_fwd_stage;
    import id_ex_fwd_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, id_valid_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_shamt_i;
    logic [3:0]  id_alu_ctrl_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic        id_alusrc_i, id_regdst_i, id_regwrite_i, id_memread_i;
    logic        id_memwrite_i, id_memtoreg_i, id_branch_i, id_uses_rt_i;
    logic        exmem_regwrite_i, memwb_regwrite_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_result_i, memwb_data_i;
    logic [31:0] alu_src1_o, alu_src2_o, store_data_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  alu_shift_o, ex_dst_o;
    logic        ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o;
    logic        ex_memtoreg_o, ex_branch_o, load_use_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    id_ex_fwd_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i), .id_shamt_i(id_shamt_i), .id_alu_ctrl_i(id_alu_ctrl_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_alusrc_i(id_alusrc_i), .id_regdst_i(id_regdst_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
        .id_memtoreg_i(id_memtoreg_i), .id_branch_i(id_branch_i), .id_uses_rt_i(id_uses_rt_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
        .exmem_result_i(exmem_result_i), .memwb_regwrite_i(memwb_regwrite_i),
        .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_shift_o(alu_shift_o), .store_data_o(store_data_o), .ex_dst_o(ex_dst_o),
        .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
        .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o),
        .ex_branch_o(ex_branch_o), .load_use_o(load_use_o)
    );

    // Reference model: the instruction currently sitting in EX.
    typedef struct packed {
        logic        valid, regwrite, memread, memwrite, memtoreg, branch, alusrc;
        logic [4:0]  rs, rt, dst, shamt;
        logic [31:0] rsd, rtd, imm;
        logic [3:0]  ctrl;
    } st_t;

    st_t m;

    // Value an EX operand would see for register r, given what is stored for it.
    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 0)                                   return d;
        if (exmem_regwrite_i && exmem_rd_i == r)      return exmem_result_i;
        if (memwb_regwrite_i && memwb_rd_i == r)      return memwb_data_i;
        return d;
    endfunction

    function automatic logic [116:0] exp_vec();
        logic [31:0] rs_v, rt_v;
        logic        lu;
        rs_v = ref_fwd(m.rs, m.rsd);
        rt_v = ref_fwd(m.rt, m.rtd);
        lu   = m.valid && m.memread && m.dst != 0 &&
               (m.dst == id_rs_i || (id_uses_rt_i && m.dst == id_rt_i));
        return {rs_v, (m.alusrc ? m.imm : rt_v), m.ctrl, m.shamt, rt_v, m.dst,
                m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.branch, lu};
    endfunction

    function automatic logic [116:0] act_vec();
        return {alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shift_o, store_data_o, ex_dst_o,
                ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o,
                ex_branch_o, load_use_o};
    endfunction

    // Advance the model with the inputs presented for this edge, then clock the DUT.
    task automatic tick();
        st_t nx;
        nx = m;
        if (!rst_i || flush_i) begin
            nx = '0;
        end else if (stall_i) begin
            nx.rsd = ref_fwd(m.rs, m.rsd);
            nx.rtd = ref_fwd(m.rt, m.rtd);
        end else begin
            nx.valid    = id_valid_i;
            nx.regwrite = id_valid_i & id_regwrite_i;
            nx.memread  = id_valid_i & id_memread_i;
            nx.memwrite = id_valid_i & id_memwrite_i;
            nx.memtoreg = id_valid_i & id_memtoreg_i;
            nx.branch   = id_valid_i & id_branch_i;
            nx.alusrc   = id_valid_i & id_alusrc_i;
            nx.rs       = id_rs_i;
            nx.rt       = id_rt_i;
            nx.dst      = id_regdst_i ? id_rd_i : id_rt_i;
            nx.rsd      = id_rs_data_i;
            nx.rtd      = id_rt_data_i;
            nx.imm      = id_imm_i;
            nx.shamt    = id_shamt_i;
            nx.ctrl     = id_alu_ctrl_i;
        end
        @(posedge clk_i);
        m = nx;
        #1;
    endtask

    task automatic set_idle();
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0;
        id_rs_data_i = '0; id_rt_data_i = '0; id_imm_i = '0; id_shamt_i = '0;
        id_alu_ctrl_i = '0; id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
        id_alusrc_i = 1'b0; id_regdst_i = 1'b0; id_regwrite_i = 1'b0; id_memread_i = 1'b0;
        id_memwrite_i = 1'b0; id_memtoreg_i = 1'b0; id_branch_i = 1'b0; id_uses_rt_i = 1'b0;
        exmem_regwrite_i = 1'b0; exmem_rd_i = '0; exmem_result_i = '0;
        memwb_regwrite_i = 1'b0; memwb_rd_i = '0; memwb_data_i = '0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_i = 1'b0; id_valid_i = 1'b1; id_rs_data_i = 32'hAAAA5555; id_rt_data_i = 32'h1234;
        id_imm_i = 32'h77; id_shamt_i = 5'd9; id_alu_ctrl_i = ALU_SRA;
        id_rs_i = 5'd3; id_rt_i = 5'd4; id_rd_i = 5'd6; id_alusrc_i = 1'b1; id_regdst_i = 1'b1;
        id_regwrite_i = 1'b1; id_memread_i = 1'b1; id_memwrite_i = 1'b1; id_memtoreg_i = 1'b1;
        id_branch_i = 1'b1;
        tick(); tick();
        n_chk++;
        if (act_vec() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", act_vec());
        end
        n_chk++;
        if (ex_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", ex_valid_o);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_plain_load();
        set_idle();
        id_valid_i = 1'b1; id_rs_data_i = 32'd5; id_rt_data_i = 32'd7; id_alu_ctrl_i = ALU_ADD;
        id_rs_i = 5'd1; id_rt_i = 5'd2; id_rd_i = 5'd3; id_regdst_i = 1'b1; id_regwrite_i = 1'b1;
        tick();
        n_chk++;
        if (alu_src1_o !== 32'd5) begin n_fail++; $display("FAIL load_src1: got %h want 5", alu_src1_o); end
        n_chk++;
        if (alu_src2_o !== 32'd7) begin n_fail++; $display("FAIL load_src2: got %h want 7", alu_src2_o); end
        n_chk++;
        if (alu_ctrl_o !== 4'b0010) begin n_fail++; $display("FAIL load_ctrl: got %b want 0010", alu_ctrl_o); end
        n_chk++;
        if (ex_dst_o !== 5'd3) begin n_fail++; $display("FAIL load_dst: got %0d want 3", ex_dst_o); end
        n_chk++;
        if ({ex_valid_o, ex_regwrite_o} !== 2'b11) begin
            n_fail++; $display("FAIL load_valid_regwrite: got %b%b want 11", ex_valid_o, ex_regwrite_o);
        end
    endtask

    task automatic test_dual_forward();
        set_idle();
        id_valid_i = 1'b1; id_rs_i = 5'd4; id_rt_i = 5'd4; id_uses_rt_i = 1'b1;
        id_rs_data_i = 32'h1; id_rt_data_i = 32'h2;
        tick();
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd4; exmem_result_i = 32'h11;
        memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd4; memwb_data_i = 32'h22;
        #1;
        n_chk++;
        if ({alu_src1_o, store_data_o, alu_src2_o} !== {32'h11, 32'h11, 32'h11}) begin
            n_fail++; $display("FAIL fwd_exmem_prio: got %h/%h/%h want 11/11/11",
                               alu_src1_o, store_data_o, alu_src2_o);
        end
        exmem_regwrite_i = 1'b0;
        #1;
        n_chk++;
        if ({alu_src1_o, store_data_o} !== {32'h22, 32'h22}) begin
            n_fail++; $display("FAIL fwd_memwb: got %h/%h want 22/22", alu_src1_o, store_data_o);
        end
    endtask

    task automatic test_r0_guard();
        set_idle();
        id_valid_i = 1'b1; id_rs_i = 5'd0; id_rs_data_i = 32'h33;
        tick();
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0; exmem_result_i = 32'hFF;
        #1;
        n_chk++;
        if (alu_src1_o !== 32'h33) begin n_fail++; $display("FAIL r0_exmem: got %h want 33", alu_src1_o); end
        exmem_regwrite_i = 1'b0; memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd0; memwb_data_i = 32'hEE;
        #1;
        n_chk++;
        if (alu_src1_o !== 32'h33) begin n_fail++; $display("FAIL r0_memwb: got %h want 33", alu_src1_o); end
    endtask

    task automatic test_load_use();
        set_idle();
        id_valid_i = 1'b1; id_memread_i = 1'b1; id_regwrite_i = 1'b1; id_memtoreg_i = 1'b1;
        id_rt_i = 5'd8; id_regdst_i = 1'b0;
        tick();
        id_memread_i = 1'b0; id_rs_i = 5'd8; id_rt_i = 5'd1; id_uses_rt_i = 1'b0;
        #1;
        n_chk++;
        if (load_use_o !== 1'b1) begin n_fail++; $display("FAIL lu_rs: got %b want 1", load_use_o); end
        id_rs_i = 5'd2; id_rt_i = 5'd8;
        #1;
        n_chk++;
        if (load_use_o !== 1'b0) begin n_fail++; $display("FAIL lu_rt_unused: got %b want 0", load_use_o); end
        id_uses_rt_i = 1'b1;
        #1;
        n_chk++;
        if (load_use_o !== 1'b1) begin n_fail++; $display("FAIL lu_rt_used: got %b want 1", load_use_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_chk++;
        if ({ex_valid_o, ex_memread_o, load_use_o} !== 3'b000) begin
            n_fail++; $display("FAIL lu_flush: got %b%b%b want 000", ex_valid_o, ex_memread_o, load_use_o);
        end
        // A load targeting r0 never raises a hazard.
        id_memread_i = 1'b1; id_rt_i = 5'd0; id_rs_i = 5'd0; id_uses_rt_i = 1'b1;
        tick();
        n_chk++;
        if (load_use_o !== 1'b0) begin n_fail++; $display("FAIL lu_r0: got %b want 0", load_use_o); end
    endtask

    task automatic test_stall_refresh();
        set_idle();
        id_valid_i = 1'b1; id_rs_i = 5'd5; id_rs_data_i = 32'h1; id_rd_i = 5'd12;
        id_regdst_i = 1'b1; id_regwrite_i = 1'b1;
        tick();
        stall_i = 1'b1; memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd5; memwb_data_i = 32'h9;
        id_rs_i = 5'd6; id_rs_data_i = 32'hDEAD; id_rd_i = 5'd20;
        tick(); tick();
        memwb_regwrite_i = 1'b0;
        #1;
        n_chk++;
        if (alu_src1_o !== 32'h9) begin n_fail++; $display("FAIL stall_refresh: got %h want 9", alu_src1_o); end
        n_chk++;
        if ({ex_dst_o, ex_valid_o} !== {5'd12, 1'b1}) begin
            n_fail++; $display("FAIL stall_hold: got dst %0d v %b want 12 1", ex_dst_o, ex_valid_o);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_chk++;
        if ({ex_valid_o, ex_regwrite_o, alu_src1_o} !== 34'd0) begin
            n_fail++; $display("FAIL flush_over_stall: got v %b rw %b src1 %h want 0",
                               ex_valid_o, ex_regwrite_o, alu_src1_o);
        end
        stall_i = 1'b0;
        tick();
        stall_i = 1'b1; rst_i = 1'b0;
        tick();
        n_chk++;
        if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_over_stall: got %b want 0", ex_valid_o); end
        rst_i = 1'b1; stall_i = 1'b0;
    endtask

    task automatic test_random();
        set_idle();
        rst_i = 1'b0;
        tick();
        for (int i = 0; i < 400; i++) begin
            rst_i = ($urandom_range(0, 39) != 0);
            flush_i = ($urandom_range(0, 9) == 0);
            stall_i = ($urandom_range(0, 4) == 0);
            id_valid_i = ($urandom_range(0, 5) != 0);
            id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
            id_shamt_i = 5'($urandom); id_alu_ctrl_i = 4'($urandom);
            id_rs_i = 5'($urandom_range(0, 7)); id_rt_i = 5'($urandom_range(0, 7));
            id_rd_i = 5'($urandom_range(0, 7));
            {id_alusrc_i, id_regdst_i, id_regwrite_i, id_memread_i} = 4'($urandom);
            {id_memwrite_i, id_memtoreg_i, id_branch_i, id_uses_rt_i} = 4'($urandom);
            exmem_regwrite_i = 1'($urandom); exmem_rd_i = 5'($urandom_range(0, 7));
            exmem_result_i = $urandom;
            memwb_regwrite_i = 1'($urandom); memwb_rd_i = 5'($urandom_range(0, 7));
            memwb_data_i = $urandom;
            #2;
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        m = '0;
        set_idle();
        @(posedge clk_i);
        #1;
        test_reset();
        test_plain_load();
        test_dual_forward();
        test_r0_guard();
        test_load_use();
        test_stall_refresh();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
